q16_16_reciprocal: RTL



---
 rtl/q16_16_reciprocal.sv | 130 +++++++++++++
 1 files changed

// File: rtl/q16_16_reciprocal.sv
// q16_16_reciprocal: signed Q16.16 reciprocal (z_inv = 1/z) built on an
// iterative restoring divider that computes 2^32 / |z|. The sign is applied
// afterwards. z == 0 and |z| <= 2 LSB are resolved on accept and flagged.
module q16_16_reciprocal #(
   parameter int ITER_PER_CYCLE = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [31:0] i_z,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_z_inv,
   output logic        o_div_by_zero,
   output logic        o_overflow
);

   if (ITER_PER_CYCLE != 1 && ITER_PER_CYCLE != 2 && ITER_PER_CYCLE != 4) begin : g_bad_param
      $error("q16_16_reciprocal: ITER_PER_CYCLE must be 1, 2 or 4");
   end

   localparam int         N_CYC  = 32 / ITER_PER_CYCLE;
   localparam logic [4:0] LAST_C = 5'(N_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   state_t      r_state;
   logic        r_sign;
   logic [32:0] r_mag;
   logic [33:0] r_rem;
   logic [31:0] r_quo;
   logic [4:0]  r_cnt;

   logic [32:0] w_mag_in;
   logic [33:0] w_rem_nxt;
   logic [31:0] w_quo_nxt;
   logic [31:0] w_res;

   // |z| held in 33 bits so that 0x80000000 maps to 2^31
   assign w_mag_in = i_z[31] ? (33'h1_0000_0000 - {1'b0, i_z}) : {1'b0, i_z};

   // Resolve ITER_PER_CYCLE quotient bits, MSB first. The numerator's low
   // 32 bits are zero, so each step shifts a zero into the partial remainder.
   always_comb begin
      w_rem_nxt = r_rem;
      w_quo_nxt = r_quo;
      for (int i = 0; i < ITER_PER_CYCLE; i++) begin
         w_rem_nxt = {w_rem_nxt[32:0], 1'b0};
         if (w_rem_nxt >= {1'b0, r_mag}) begin
            w_rem_nxt = w_rem_nxt - {1'b0, r_mag};
            w_quo_nxt = {w_quo_nxt[30:0], 1'b1};
         end else begin
            w_quo_nxt = {w_quo_nxt[30:0], 1'b0};
         end
      end
   end

   assign w_res = r_sign ? (~w_quo_nxt + 32'd1) : w_quo_nxt;

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_sign        <= 1'b0;
         r_mag         <= '0;
         r_rem         <= '0;
         r_quo         <= '0;
         r_cnt         <= '0;
         o_in_ready    <= 1'b1;
         o_out_valid   <= 1'b0;
         o_z_inv       <= '0;
         o_div_by_zero <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_in_valid && o_in_ready) begin
                  r_sign     <= i_z[31];
                  r_mag      <= w_mag_in;
                  o_in_ready <= 1'b0;
                  if (i_z == 32'd0) begin
                     r_state       <= S_DONE;
                     o_out_valid   <= 1'b1;
                     o_z_inv       <= 32'h7FFF_FFFF;
                     o_div_by_zero <= 1'b1;
                  end else if (w_mag_in <= 33'd2) begin
                     r_state     <= S_DONE;
                     o_out_valid <= 1'b1;
                     o_z_inv     <= i_z[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                     o_overflow  <= 1'b1;
                  end else begin
                     // Numerator bit 32 is preloaded into the remainder:
                     // with |z| >= 3 that quotient bit is always 0.
                     r_state <= S_DIV;
                     r_rem   <= 34'd1;
                     r_quo   <= '0;
                     r_cnt   <= '0;
                  end
               end
            end
            S_DIV: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == LAST_C) begin
                  r_state     <= S_DONE;
                  o_out_valid <= 1'b1;
                  o_z_inv     <= w_res;
               end
            end
            S_DONE: begin
               if (i_out_ready) begin
                  r_state       <= S_IDLE;
                  o_out_valid   <= 1'b0;
                  o_in_ready    <= 1'b1;
                  o_div_by_zero <= 1'b0;
                  o_overflow    <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               o_in_ready  <= 1'b1;
               o_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
